// File: rtl/cpu_pkg.sv
// Shared widths, reader FSM states and reset data for the operand reader.
// Used by operand_reader, operand_bypass and operand_reader_if.
package cpu_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 2;
  localparam int OP_WIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    CAPTURE = 2'd2,
    VALID   = 2'd3
  } reader_state_t;

  localparam logic [DATA_WIDTH-1:0] RESET_DATA = '0;

endpackage

// File: rtl/operand_reader_if.sv
// Decoder-side and ALU-side valid/ready bundle of the operand reader.
// slave: the reader itself; master: its environment.
interface operand_reader_if #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int OP_WIDTH   = cpu_pkg::OP_WIDTH
) ();

  logic                  Instr_valid;
  logic                  Instr_ready;
  logic [OP_WIDTH-1:0]   Instr_op;
  logic [ADDR_WIDTH-1:0] Instr_src_A;
  logic [ADDR_WIDTH-1:0] Instr_src_B;
  logic [ADDR_WIDTH-1:0] Instr_dest;

  logic                  Op_valid;
  logic                  Op_ready;
  logic [DATA_WIDTH-1:0] Operand_A;
  logic [DATA_WIDTH-1:0] Operand_B;
  logic [OP_WIDTH-1:0]   Op_out;
  logic [ADDR_WIDTH-1:0] Dest_out;

  modport slave (
    input  Instr_valid, Instr_op,
    input  Instr_src_A, Instr_src_B,
    input  Instr_dest, Op_ready,
    output Instr_ready, Op_valid,
    output Operand_A, Operand_B,
    output Op_out, Dest_out
  );

  modport master (
    output Instr_valid, Instr_op,
    output Instr_src_A, Instr_src_B,
    output Instr_dest, Op_ready,
    input  Instr_ready, Op_valid,
    input  Operand_A, Operand_B,
    input  Op_out, Dest_out
  );

endinterface

// File: rtl/operand_bypass.sv
// One read port's writeback snoop: address compare, saved
// collision flag and data, and the operand select.
module operand_bypass #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic                  wb_enable,
  input  logic [ADDR_WIDTH-1:0] wb_address,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] data
);
  import cpu_pkg::*;

  logic                  flag;
  logic [DATA_WIDTH-1:0] saved;

  assign hit = sample && wb_enable &&
               (wb_address == src);

  // Remember the write that the file's read will miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag  <= 1'b0;
      saved <= DATA_WIDTH'(RESET_DATA);
    end else if (sample) begin
      flag  <= hit;
      saved <= wb_data;
    end
  end

  assign data = flag ? saved : read_data;

endmodule

// File: rtl/operand_reader.sv
// Register-file read stage between decoder and ALU.
// Macro REGREAD_BYPASS_EN: forward colliding writes instead of re-reading.
module operand_reader #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int OP_WIDTH   = cpu_pkg::OP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_reader_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] Read_address_A,
  output logic [ADDR_WIDTH-1:0] Read_address_B,
  input  logic [DATA_WIDTH-1:0] Read_data_A,
  input  logic [DATA_WIDTH-1:0] Read_data_B,
  input  logic                  Wb_enable,
  input  logic [ADDR_WIDTH-1:0] Wb_address,
  input  logic [DATA_WIDTH-1:0] Wb_data
);
  import cpu_pkg::*;

  reader_state_t         state;
  logic [OP_WIDTH-1:0]   op;
  logic [ADDR_WIDTH-1:0] src_a;
  logic [ADDR_WIDTH-1:0] src_b;
  logic [ADDR_WIDTH-1:0] dest;
  logic [DATA_WIDTH-1:0] opnd_a;
  logic [DATA_WIDTH-1:0] opnd_b;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic                  hit_a;
  logic                  hit_b;
  logic                  in_addr;
  logic                  stall;

  assign in_addr = (state == ADDR);

`ifdef REGREAD_BYPASS_EN
  assign stall = 1'b0;
`else
  assign stall = hit_a | hit_b;
`endif

  operand_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_byp_a (
    .clk        (clk),
    .rst        (rst),
    .sample     (in_addr),
    .src        (src_a),
    .wb_enable  (Wb_enable),
    .wb_address (Wb_address),
    .wb_data    (Wb_data),
    .read_data  (Read_data_A),
    .hit        (hit_a),
    .data       (sel_a)
  );

  operand_bypass #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_byp_b (
    .clk        (clk),
    .rst        (rst),
    .sample     (in_addr),
    .src        (src_b),
    .wb_enable  (Wb_enable),
    .wb_address (Wb_address),
    .wb_data    (Wb_data),
    .read_data  (Read_data_B),
    .hit        (hit_b),
    .data       (sel_b)
  );

  // Accept, read, capture, then hold until the ALU takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= '0;
      src_a  <= '0;
      src_b  <= '0;
      dest   <= '0;
      opnd_a <= DATA_WIDTH'(RESET_DATA);
      opnd_b <= DATA_WIDTH'(RESET_DATA);
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Instr_valid) begin
            op    <= bus.Instr_op;
            src_a <= bus.Instr_src_A;
            src_b <= bus.Instr_src_B;
            dest  <= bus.Instr_dest;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (!stall) state <= CAPTURE;
        end
        CAPTURE: begin
          opnd_a <= sel_a;
          opnd_b <= sel_b;
          state  <= VALID;
        end
        VALID: begin
          if (bus.Op_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Read_address_A  = rst ? '0 : src_a;
  assign Read_address_B  = rst ? '0 : src_b;
  assign bus.Instr_ready = (state == IDLE) && !rst;
  assign bus.Op_valid    = (state == VALID);
  assign bus.Operand_A   = opnd_a;
  assign bus.Operand_B   = opnd_b;
  assign bus.Op_out      = op;
  assign bus.Dest_out    = dest;

endmodule

// File: tb/tb_operand_reader.sv
// Directed bench for operand_reader with a behavioural
// synchronous read-before-write register file.
module tb_operand_reader;

  logic       clk;
  logic       rst;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic [7:0] rd_data_a;
  logic [7:0] rd_data_b;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic [7:0] rf [4];

  int tests = 0;
  int fails = 0;
  int n;
  int outs;
  int k;
  bit pending;
  int acc [3];

`ifdef REGREAD_BYPASS_EN
  localparam int STALL = 0;
`else
  localparam int STALL = 1;
`endif

  operand_reader_if bus ();

  operand_reader dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .Read_address_A (rd_addr_a),
    .Read_address_B (rd_addr_b),
    .Read_data_A    (rd_data_a),
    .Read_data_B    (rd_data_b),
    .Wb_enable      (wb_en),
    .Wb_address     (wb_addr),
    .Wb_data        (wb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: old data on same-edge write.
  always @(posedge clk) begin
    rd_data_a <= rf[rd_addr_a];
    rd_data_b <= rf[rd_addr_b];
    if (wb_en) rf[wb_addr] <= wb_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [7:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    tick();
    wb_en   = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [1:0] a,
                       input logic [1:0] b,
                       input logic [1:0] d);
    chk("accept_ready", bus.Instr_ready, 1);
    bus.Instr_valid = 1'b1;
    bus.Instr_op    = op;
    bus.Instr_src_A = a;
    bus.Instr_src_B = b;
    bus.Instr_dest  = d;
    tick();
    bus.Instr_valid = 1'b0;
    chk("rd_addr_a", rd_addr_a, a);
    chk("rd_addr_b", rd_addr_b, b);
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (bus.Op_valid !== 1'b1 && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("valid_timeout", bus.Op_valid, 1);
  endtask

  task automatic release_op();
    bus.Op_ready = 1'b1;
    tick();
    bus.Op_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wb_en = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    bus.Instr_valid = 1'b0;
    bus.Instr_op = '0;
    bus.Instr_src_A = '0;
    bus.Instr_src_B = '0;
    bus.Instr_dest = '0;
    bus.Op_ready = 1'b0;

    tick();
    tick();
    chk("rst_ready", bus.Instr_ready, 0);
    chk("rst_valid", bus.Op_valid, 0);
    chk("rst_opnd_a", bus.Operand_A, 0);
    chk("rst_dest", bus.Dest_out, 0);
    chk("rst_rdaddr", rd_addr_a, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.Instr_ready, 1);

    wr(2'd0, 8'h11);
    wr(2'd1, 8'h3C);
    wr(2'd2, 8'hA5);
    wr(2'd3, 8'hC3);

    // basic read
    issue(4'h3, 2'd1, 2'd2, 2'd3);
    wait_valid(n);
    chk("basic_lat", n, 2);
    chk("basic_a", bus.Operand_A, 8'h3C);
    chk("basic_b", bus.Operand_B, 8'hA5);
    chk("basic_op", bus.Op_out, 4'h3);
    chk("basic_dest", bus.Dest_out, 2'd3);

    // backpressure with an ignored offer
    bus.Instr_valid = 1'b1;
    bus.Instr_op    = 4'hF;
    bus.Instr_src_A = 2'd0;
    bus.Instr_src_B = 2'd0;
    bus.Instr_dest  = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", bus.Op_valid, 1);
      chk("bp_ready", bus.Instr_ready, 0);
      chk("bp_a", bus.Operand_A, 8'h3C);
      chk("bp_op", bus.Op_out, 4'h3);
    end
    bus.Instr_valid = 1'b0;
    release_op();
    chk("bp_idle_ready", bus.Instr_ready, 1);
    chk("bp_idle_valid", bus.Op_valid, 0);
    chk("bp_keep_dest", bus.Dest_out, 2'd3);

    // reset while VALID
    issue(4'h5, 2'd3, 2'd0, 2'd1);
    wait_valid(n);
    chk("pre_rst_a", bus.Operand_A, 8'hC3);
    chk("pre_rst_b", bus.Operand_B, 8'h11);
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", bus.Instr_ready, 0);
    chk("mid_rst_valid", bus.Op_valid, 0);
    chk("mid_rst_a", bus.Operand_A, 0);
    chk("mid_rst_op", bus.Op_out, 0);
    tick();
    chk("mid_rst_ready2", bus.Instr_ready, 0);
    rst = 1'b0;
    tick();
    chk("after_rst_ready", bus.Instr_ready, 1);
    chk("after_rst_valid", bus.Op_valid, 0);

    // collision on both ports, same register
    wr(2'd1, 8'h10);
    issue(4'h7, 2'd1, 2'd1, 2'd2);
    wb_en = 1'b1;
    wb_addr = 2'd1;
    wb_data = 8'h77;
    tick();
    wb_en = 1'b0;
    wait_valid(n);
    chk("coll_lat", n + 1, 2 + STALL);
    chk("coll_a", bus.Operand_A, 8'h77);
    chk("coll_b", bus.Operand_B, 8'h77);
    chk("coll_op", bus.Op_out, 4'h7);
    release_op();

    // collision on port B only
    issue(4'h8, 2'd2, 2'd3, 2'd0);
    wb_en = 1'b1;
    wb_addr = 2'd3;
    wb_data = 8'h99;
    tick();
    wb_en = 1'b0;
    wait_valid(n);
    chk("collb_lat", n + 1, 2 + STALL);
    chk("collb_a", bus.Operand_A, 8'hA5);
    chk("collb_b", bus.Operand_B, 8'h99);
    release_op();

    // unrelated write in ADDR, late write in CAPTURE
    wr(2'd1, 8'h10);
    issue(4'h9, 2'd1, 2'd1, 2'd1);
    wb_en = 1'b1;
    wb_addr = 2'd0;
    wb_data = 8'hEE;
    tick();
    wb_addr = 2'd1;
    wb_data = 8'h55;
    tick();
    wb_en = 1'b0;
    chk("late_valid", bus.Op_valid, 1);
    chk("late_a", bus.Operand_A, 8'h10);
    chk("late_b", bus.Operand_B, 8'h10);
    release_op();

    // back-to-back: rf = EE,55,A5,99
    bus.Op_ready = 1'b1;
    bus.Instr_valid = 1'b1;
    bus.Instr_op = 4'h1;
    bus.Instr_src_A = 2'd0;
    bus.Instr_src_B = 2'd1;
    bus.Instr_dest = 2'd1;
    k = 0;
    outs = 0;
    for (int c = 0; c < 30 && outs < 3; c++) begin
      pending = 1'b0;
      if (bus.Instr_valid && bus.Instr_ready) begin
        acc[k] = c;
        pending = 1'b1;
      end
      if (bus.Op_valid) begin
        if (outs == 0) begin
          chk("tp0_a", bus.Operand_A, 8'hEE);
          chk("tp0_b", bus.Operand_B, 8'h55);
          chk("tp0_op", bus.Op_out, 4'h1);
        end else if (outs == 1) begin
          chk("tp1_a", bus.Operand_A, 8'hA5);
          chk("tp1_b", bus.Operand_B, 8'h99);
          chk("tp1_op", bus.Op_out, 4'h2);
        end else begin
          chk("tp2_a", bus.Operand_A, 8'h99);
          chk("tp2_b", bus.Operand_B, 8'hEE);
          chk("tp2_dest", bus.Dest_out, 2'd3);
        end
        outs++;
      end
      tick();
      if (pending) begin
        k++;
        if (k == 1) begin
          bus.Instr_op = 4'h2;
          bus.Instr_src_A = 2'd2;
          bus.Instr_src_B = 2'd3;
          bus.Instr_dest = 2'd2;
        end else if (k == 2) begin
          bus.Instr_op = 4'h4;
          bus.Instr_src_A = 2'd3;
          bus.Instr_src_B = 2'd0;
          bus.Instr_dest = 2'd3;
        end else begin
          bus.Instr_valid = 1'b0;
        end
      end
    end
    bus.Instr_valid = 1'b0;
    bus.Op_ready = 1'b0;
    chk("tp_outs", outs, 3);
    chk("tp_accepts", k, 3);
    chk("tp_gap1", acc[1] - acc[0], 4);
    chk("tp_gap2", acc[2] - acc[1], 4);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
